// File: rtl/fu_issue_sched_pkg.sv
// Shared types and defaults for the functional-unit issue scheduler.
// FU class encoding is shared with the reservation station.
package fu_issue_sched_pkg;

    typedef enum logic [1:0] {
        ALU  = 2'd0,
        MULT = 2'd1,
        LS   = 2'd2,
        BR   = 2'd3
    } func_unit_e;

    localparam int MULT_LAT_DEFAULT = 4;

endpackage

// File: rtl/fu_issue_sched_prio_pick.sv
// Lowest-index one-hot picker with exclusion mask, any-valid flag and
// a one-hot-to-index encoder for the picked slot.
module prio_pick #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] eligible;
    logic         found;

    assign eligible = req & ~mask;
    assign any      = |eligible;

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && !found) begin
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fu_issue_sched.sv
// Per-cycle oldest-first issue scheduler: 2x ALU/BR, 1x MULT, 1x LS.
// Optional stall counters are built when FU_SCHED_PERF_EN is defined.
module fu_issue_sched
    import fu_issue_sched_pkg::*;
#(
    parameter int RS_SIZE  = 16,
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int IDX_W    = $clog2(RS_SIZE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    input  logic [RS_SIZE-1:0]   req,
    input  logic [2*RS_SIZE-1:0] func_in,
    output logic [RS_SIZE-1:0]   gnt,
    output logic                 alu0_valid,
    output logic [IDX_W-1:0]     alu0_idx,
    output logic                 alu1_valid,
    output logic [IDX_W-1:0]     alu1_idx,
    output logic                 mult_valid,
    output logic [IDX_W-1:0]     mult_idx,
    output logic                 ls_valid,
    output logic [IDX_W-1:0]     ls_idx,
    input  logic                 ls_ready,
    output logic                 mult_busy
`ifdef FU_SCHED_PERF_EN
    ,
    output logic [31:0]          mult_stall_cnt,
    output logic [31:0]          ls_stall_cnt
`endif
);

    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    logic [RS_SIZE-1:0] alu_req, mult_req, ls_req;
    logic [RS_SIZE-1:0] alu0_oh, alu1_oh, mult_oh, ls_oh;
    logic [IDX_W-1:0]   alu0_pick_idx, alu1_pick_idx, mult_pick_idx, ls_pick_idx;
    logic               alu0_any, alu1_any, mult_any, ls_any;
    logic [CNT_W-1:0]   mult_cnt;
    logic               ls_slot_free;
    logic               alu0_grant, alu1_grant, mult_grant, ls_grant;

    always_comb begin
        alu_req  = '0;
        mult_req = '0;
        ls_req   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            unique case (func_unit_e'(func_in[2*i +: 2]))
                ALU, BR: alu_req[i]  = req[i];
                MULT:    mult_req[i] = req[i];
                LS:      ls_req[i]   = req[i];
                default: ;
            endcase
        end
    end

    prio_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_alu0 (
        .req(alu_req), .mask('0), .onehot(alu0_oh), .idx(alu0_pick_idx), .any(alu0_any)
    );

    // Second ALU pick excludes the first, so the two lanes never collide.
    prio_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_alu1 (
        .req(alu_req), .mask(alu0_oh), .onehot(alu1_oh), .idx(alu1_pick_idx), .any(alu1_any)
    );

    prio_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_mult (
        .req(mult_req), .mask('0), .onehot(mult_oh), .idx(mult_pick_idx), .any(mult_any)
    );

    prio_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ls (
        .req(ls_req), .mask('0), .onehot(ls_oh), .idx(ls_pick_idx), .any(ls_any)
    );

    // LS output register can be reloaded in the same cycle it is accepted.
    assign ls_slot_free = !ls_valid || ls_ready;

    assign alu0_grant = alu0_any && !squash;
    assign alu1_grant = alu1_any && !squash;
    assign mult_grant = mult_any && (mult_cnt == '0) && !squash;
    assign ls_grant   = ls_any && ls_slot_free && !squash;

    assign gnt = (alu0_oh & {RS_SIZE{alu0_grant}})
               | (alu1_oh & {RS_SIZE{alu1_grant}})
               | (mult_oh & {RS_SIZE{mult_grant}})
               | (ls_oh   & {RS_SIZE{ls_grant}});

    assign mult_busy = (mult_cnt != '0);

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            alu0_valid <= 1'b0;
            alu0_idx   <= '0;
            alu1_valid <= 1'b0;
            alu1_idx   <= '0;
            mult_valid <= 1'b0;
            mult_idx   <= '0;
            ls_valid   <= 1'b0;
            ls_idx     <= '0;
            mult_cnt   <= '0;
        end else if (squash) begin
            alu0_valid <= 1'b0;
            alu1_valid <= 1'b0;
            mult_valid <= 1'b0;
            ls_valid   <= 1'b0;
            mult_cnt   <= '0;
        end else begin
            alu0_valid <= alu0_grant;
            if (alu0_grant) alu0_idx <= alu0_pick_idx;
            alu1_valid <= alu1_grant;
            if (alu1_grant) alu1_idx <= alu1_pick_idx;

            mult_valid <= mult_grant;
            if (mult_grant) begin
                mult_idx <= mult_pick_idx;
                mult_cnt <= CNT_W'(MULT_LAT - 1);
            end else if (mult_cnt != '0) begin
                mult_cnt <= mult_cnt - 1'b1;
            end

            if (ls_slot_free) begin
                ls_valid <= ls_grant;
                if (ls_grant) ls_idx <= ls_pick_idx;
            end
        end
    end

`ifdef FU_SCHED_PERF_EN
    // Stall counters survive squash so flushes do not hide structural stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mult_stall_cnt <= '0;
            ls_stall_cnt   <= '0;
        end else begin
            if (mult_any && mult_busy) mult_stall_cnt <= mult_stall_cnt + 32'd1;
            if (ls_any && !ls_slot_free) ls_stall_cnt <= ls_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fu_issue_sched.sv
// Scoreboard bench for fu_issue_sched: driver queues expected grants and
// issue indices, a negedge monitor pops them as the DUT presents outputs.
module tb_fu_issue_sched;
    import fu_issue_sched_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        squash;
    logic [15:0] req;
    logic [31:0] func_in;
    logic [15:0] gnt;
    logic        alu0_valid, alu1_valid, mult_valid, ls_valid;
    logic [3:0]  alu0_idx, alu1_idx, mult_idx, ls_idx;
    logic        ls_ready;
    logic        mult_busy;
`ifdef FU_SCHED_PERF_EN
    logic [31:0] mult_stall_cnt, ls_stall_cnt;
`endif

    fu_issue_sched #(.RS_SIZE(16), .MULT_LAT(4)) dut (
        .clock(clock), .reset(reset), .squash(squash), .req(req), .func_in(func_in),
        .gnt(gnt),
        .alu0_valid(alu0_valid), .alu0_idx(alu0_idx),
        .alu1_valid(alu1_valid), .alu1_idx(alu1_idx),
        .mult_valid(mult_valid), .mult_idx(mult_idx),
        .ls_valid(ls_valid), .ls_idx(ls_idx),
        .ls_ready(ls_ready), .mult_busy(mult_busy)
`ifdef FU_SCHED_PERF_EN
        , .mult_stall_cnt(mult_stall_cnt), .ls_stall_cnt(ls_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] gnt;
        logic        mb;
    } exp_t;

    exp_t       gnt_q[$];
    logic [3:0] alu0_q[$], alu1_q[$], mult_q[$], ls_q[$];

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic ls_seen = 1'b0;
    logic [3:0] ls_held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [3:0] idx);
        checks++;
        errors++;
        $display("FAIL %s: got issue idx %0d expected no issue at %0t", name, idx, $time);
    endtask

    function automatic logic [31:0] fset(input logic [31:0] f, input int slot, input func_unit_e u);
        logic [31:0] r;
        r = f;
        r[2*slot +: 2] = u;
        return r;
    endfunction

    // One cycle of stimulus; -1 means that lane issues nothing.
    task automatic step(input logic [15:0] r, input logic [31:0] f, input logic sq, input logic lr,
                        input logic [15:0] egnt, input logic emb,
                        input int a0, input int a1, input int m, input int l);
        exp_t e;
        @(posedge clock);
        #1;
        req = r; func_in = f; squash = sq; ls_ready = lr;
        e.gnt = egnt;
        e.mb  = emb;
        gnt_q.push_back(e);
        if (a0 >= 0) alu0_q.push_back(a0[3:0]);
        if (a1 >= 0) alu1_q.push_back(a1[3:0]);
        if (m  >= 0) mult_q.push_back(m[3:0]);
        if (l  >= 0) ls_q.push_back(l[3:0]);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (gnt_q.size() > 0) begin
                exp_t e;
                e = gnt_q.pop_front();
                check("gnt", 32'(gnt), 32'(e.gnt));
                check("mult_busy", 32'(mult_busy), 32'(e.mb));
            end
            if (alu0_valid) begin
                if (alu0_q.size() == 0) unexpected("alu0", alu0_idx);
                else check("alu0_idx", 32'(alu0_idx), 32'(alu0_q.pop_front()));
            end
            if (alu1_valid) begin
                if (alu1_q.size() == 0) unexpected("alu1", alu1_idx);
                else check("alu1_idx", 32'(alu1_idx), 32'(alu1_q.pop_front()));
            end
            if (mult_valid) begin
                if (mult_q.size() == 0) unexpected("mult", mult_idx);
                else check("mult_idx", 32'(mult_idx), 32'(mult_q.pop_front()));
            end
            if (ls_valid) begin
                if (!ls_seen) begin
                    if (ls_q.size() == 0) unexpected("ls", ls_idx);
                    else begin
                        ls_held = ls_q.pop_front();
                        check("ls_idx", 32'(ls_idx), 32'(ls_held));
                    end
                    ls_seen = 1'b1;
                end else begin
                    check("ls_idx_hold", 32'(ls_idx), 32'(ls_held));
                end
                if (ls_ready || squash) ls_seen = 1'b0;
            end
        end
    end

    logic [31:0] f_all_alu, f_mix, f_mult, f_ls, f_m0;

    initial begin
        f_all_alu = '0;
        f_mix = fset(fset(fset(fset('0, 1, MULT), 2, LS), 5, ALU), 9, BR);
        f_mult = fset(fset(fset(fset('0, 0, MULT), 1, MULT), 2, MULT), 3, MULT);
        f_ls = fset(fset('0, 4, LS), 7, LS);
        f_m0 = fset('0, 0, MULT);

        reset = 1'b0; squash = 1'b0; req = '0; func_in = '0; ls_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_alu0_valid", 32'(alu0_valid), 0);
        check("rst_alu1_valid", 32'(alu1_valid), 0);
        check("rst_mult_valid", 32'(mult_valid), 0);
        check("rst_ls_valid", 32'(ls_valid), 0);
        check("rst_ls_idx", 32'(ls_idx), 0);
        check("rst_mult_busy", 32'(mult_busy), 0);
        check("rst_gnt", 32'(gnt), 0);
        reset = 1'b1;
        mon_en = 1'b1;

        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 0, -1, -1, -1, -1);
        // Two oldest ALU picks, slot 6 waits a cycle.
        step(16'h0058, f_all_alu, 0, 0, 16'h0018, 0, 3, 4, -1, -1);
        step(16'h0040, f_all_alu, 0, 0, 16'h0040, 0, 6, -1, -1, -1);
        // All four classes in one cycle.
        step(16'h0226, f_mix, 0, 0, 16'h0226, 0, 5, 9, 1, 2);
        step(16'h0000, f_all_alu, 0, 1, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 0, -1, -1, -1, -1);
        // Multiplier occupancy: grants at t, t+4, t+8.
        step(16'h000F, f_mult, 0, 0, 16'h0001, 0, -1, -1, 0, -1);
        step(16'h000E, f_mult, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h000E, f_mult, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h000E, f_mult, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h000E, f_mult, 0, 0, 16'h0002, 0, -1, -1, 1, -1);
        step(16'h000C, f_mult, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h000C, f_mult, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h000C, f_mult, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h000C, f_mult, 0, 0, 16'h0004, 0, -1, -1, 2, -1);
        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 0, -1, -1, -1, -1);
        // LS backpressure, then accept-and-replace.
        step(16'h0010, f_ls, 0, 0, 16'h0010, 0, -1, -1, -1, 4);
        step(16'h0080, f_ls, 0, 0, 16'h0000, 0, -1, -1, -1, -1);
        step(16'h0080, f_ls, 0, 0, 16'h0000, 0, -1, -1, -1, -1);
        step(16'h0080, f_ls, 0, 0, 16'h0000, 0, -1, -1, -1, -1);
        step(16'h0080, f_ls, 0, 1, 16'h0080, 0, -1, -1, -1, 7);
        // Squash with ls_valid held and mult_cnt == 2.
        step(16'h0001, f_m0, 0, 0, 16'h0001, 0, -1, -1, 0, -1);
        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h0022, f_all_alu, 1, 1, 16'h0000, 1, -1, -1, -1, -1);
        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 0, -1, -1, -1, -1);
        // Extreme slots 0 and 15.
        step(16'h8001, f_all_alu, 0, 0, 16'h8001, 0, 0, 15, -1, -1);
        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 0, -1, -1, -1, -1);
        step(16'h0000, f_all_alu, 0, 0, 16'h0000, 0, -1, -1, -1, -1);
        @(negedge clock);
        #1;
        mon_en = 1'b0;
        check("drain_gnt_q", gnt_q.size(), 0);
        check("drain_alu0_q", alu0_q.size(), 0);
        check("drain_alu1_q", alu1_q.size(), 0);
        check("drain_mult_q", mult_q.size(), 0);
        check("drain_ls_q", ls_q.size(), 0);

        // Asynchronous reset in the middle of a live cycle.
        @(posedge clock); #1;
        req = 16'h0226; func_in = f_mix; ls_ready = 1'b0;
        @(posedge clock); #1;
        req = 16'h0000;
        check("pre_rst_alu0_valid", 32'(alu0_valid), 1);
        check("pre_rst_ls_valid", 32'(ls_valid), 1);
        check("pre_rst_mult_busy", 32'(mult_busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_alu0_valid", 32'(alu0_valid), 0);
        check("async_alu0_idx", 32'(alu0_idx), 0);
        check("async_alu1_valid", 32'(alu1_valid), 0);
        check("async_alu1_idx", 32'(alu1_idx), 0);
        check("async_mult_valid", 32'(mult_valid), 0);
        check("async_mult_idx", 32'(mult_idx), 0);
        check("async_ls_valid", 32'(ls_valid), 0);
        check("async_ls_idx", 32'(ls_idx), 0);
        check("async_mult_busy", 32'(mult_busy), 0);
`ifdef FU_SCHED_PERF_EN
        check("async_mult_stall_cnt", mult_stall_cnt, 0);
        check("async_ls_stall_cnt", ls_stall_cnt, 0);
`endif
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, required finish before %0t", $time);
        $fatal(1);
    end

endmodule
